// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the MIPS32 fetch stage: reset PC, nop word, the
// pcsource encodings coming from decode, the fetch FSM state codes, the
// IF/ID payload struct and the redirect target selector.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;

  // Redirect source chosen by decode for the instruction currently in ID.
  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_JR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_BR  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifid_word_t;

  function automatic logic [31:0] select_target(
    input logic [1:0]  src,
    input logic [31:0] bpc,
    input logic [31:0] jpc,
    input logic [31:0] jr_target
  );
    case (src)
      PCSRC_BR: select_target = bpc;
      PCSRC_J:  select_target = jpc;
      default:  select_target = jr_target;
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// SRAM-like instruction port. The fetch stage is the master: it raises
// inst_req with a stable inst_addr until inst_addr_ok, then waits for
// inst_data_ok with the word on inst_rdata. inst_wr/inst_size are constant
// (read, 4 bytes).
//   master : drives inst_req, inst_addr, inst_wr, inst_size
//   slave  : drives inst_addr_ok, inst_data_ok, inst_rdata
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr, inst_wr, inst_size,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr, inst_wr, inst_size,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/fetch_stage_inst_skid_buf.sv
// -----------------------------------------------------------------------------
// inst_skid_buf
// One-entry holding register for a fetched {inst, pc} that arrives while
// decode is stalled.
//   clk, rst : clock, synchronous active-high reset (empties the buffer)
//   load     : capture din
//   unload   : release the held entry
//   din/dout : held payload
//   full     : an entry is held
// -----------------------------------------------------------------------------
module inst_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       unload,
  input  ifid_word_t din,
  output ifid_word_t dout,
  output logic       full
);

  ifid_word_t data_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; it is only observed while full=1, so
  // resetting it would add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= din;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage plus IF/ID register of the MIPS32 pipeline. Owns the PC, issues
// one fetch at a time on the instruction port, applies decode's redirect
// after the branch delay slot and holds fetched words across decode stalls.
//   clk, rst   : clock, synchronous active-high reset
//   imem       : instruction port (master side)
//   id_stall   : decode cannot accept; honoured only while id_valid=1
//   pcsource   : redirect select from decode (BR/J/JR/SEQ)
//   bpc, jpc, jr_target : redirect targets
//   id_valid, id_inst, id_pc : IF/ID register towards decode
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               id_stall,
  input  logic [1:0]         pcsource,
  input  logic [31:0]        bpc,
  input  logic [31:0]        jpc,
  input  logic [31:0]        jr_target,
  output logic               id_valid,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc
);

  fetch_state_e state, state_nxt;

  logic [31:0] next_pc;   // address of the next request to issue
  logic [31:0] req_pc;    // address of the outstanding request
  logic [31:0] tgt;       // redirect target waiting for the slot to issue
  logic        tgt_pend;

  logic        addr_acc, data_in, id_hold, to_skid, skid_release;
  logic        redirect, slot_taken;
  logic [31:0] redir_tgt;
  ifid_word_t  skid_dout;
  logic        skid_full;

  assign addr_acc     = (state == ST_REQ)  & imem.inst_addr_ok;
  assign data_in      = (state == ST_WAIT) & imem.inst_data_ok;
  assign id_hold      = id_valid & id_stall;
  assign to_skid      = data_in & id_hold;
  assign skid_release = skid_full & ~id_stall;
  assign redirect     = id_valid & ~id_stall & (pcsource != PCSRC_SEQ);
  assign redir_tgt    = select_target(pcsource, bpc, jpc, jr_target);
  // The delay slot (id_pc+4) has already been accepted once next_pc moved past it.
  assign slot_taken   = (next_pc == id_pc + 32'd8);

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  if (imem.inst_addr_ok) state_nxt = ST_WAIT;
      ST_WAIT: if (imem.inst_data_ok) state_nxt = id_hold ? ST_HOLD : ST_REQ;
      ST_HOLD: if (!id_stall) state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    imem.inst_req  = (state == ST_REQ);
    imem.inst_addr = next_pc;
    imem.inst_wr   = 1'b0;
    imem.inst_size = INST_SIZE_WORD;
  end

  // ---- PC / redirect tracking ----
  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc  <= RESET_PC;
      req_pc   <= RESET_PC;
      tgt      <= RESET_PC;
      tgt_pend <= 1'b0;
    end else if (addr_acc) begin
      req_pc   <= next_pc;
      tgt_pend <= 1'b0;
      // A redirect landing on this accept means the accepted word is the
      // delay slot, so the target is the very next request.
      if (redirect) begin
        next_pc <= redir_tgt;
      end else if (tgt_pend) begin
        next_pc <= tgt;
      end else begin
        next_pc <= next_pc + 32'd4;
      end
    end else if (redirect) begin
      if (slot_taken) begin
        next_pc <= redir_tgt;
      end else begin
        tgt_pend <= 1'b1;
        tgt      <= redir_tgt;
      end
    end
  end

  // ---- IF/ID register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_WORD;
      id_pc    <= 32'h0;
    end else if (!id_hold) begin
      if (data_in) begin
        id_valid <= 1'b1;
        id_inst  <= imem.inst_rdata;
        id_pc    <= req_pc;
      end else if (skid_release) begin
        id_valid <= 1'b1;
        id_inst  <= skid_dout.inst;
        id_pc    <= skid_dout.pc;
      end else begin
        id_valid <= 1'b0;
        id_inst  <= NOP_WORD;
      end
    end
  end

  inst_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (to_skid),
    .unload (skid_release),
    .din    ('{inst: imem.inst_rdata, pc: req_pc}),
    .dout   (skid_dout),
    .full   (skid_full)
  );

endmodule
